// File: rtl/actuator_matrix_sequencer.sv
// Scans a ROWS x COLS actuator matrix one column/polarity at a time with dead time between phases.
// Optional: define ACTUATOR_SEQ_TRIGGER_EN to gate scanning on trigger_in_n and pulse trigger_out_n.
module actuator_matrix_sequencer #(
    parameter int unsigned ROWS        = 5,
    parameter int unsigned COLS        = 2,
    parameter int unsigned DEAD_CYCLES = 4,
    parameter int unsigned PW          = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable_n,
    input  logic                     trigger_in_n,
    input  logic [2*ROWS*COLS-1:0]   frame_data,
    input  logic [PW-1:0]            pulse_len,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    output logic [ROWS-1:0]          rows,
    output logic [COLS-1:0]          cols,
    output logic [ROWS-1:0]          rows_enable,
    output logic [COLS-1:0]          cols_enable,
    output logic [2*ROWS-1:0]        rows_hbrige,
    output logic [2*COLS-1:0]        cols_hbrige,
    output logic                     trigger_out_n,
    output logic                     busy
);

    localparam int unsigned NPH = 2 * COLS;
    localparam int unsigned PHW = $clog2(NPH);
    localparam int unsigned DW  = $clog2(DEAD_CYCLES + 1);
    localparam int unsigned CW  = (PW > DW) ? PW : DW;
    localparam logic [CW-1:0] DeadLoad = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] CntOne   = CW'(1);

    typedef enum logic [2:0] {StIdle, StArm, StDead, StDrive, StFinal, StDone} state_e;

    state_e                  state_q, state_d;
    logic [PHW-1:0]          phase_q, phase_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2*ROWS*COLS-1:0]  frame_q;
    logic [PW-1:0]           pulse_q;
    logic                    capture, scan_next;
    logic [1:0]              en_sync_q;
    logic                    en_s;
    logic [NPH-1:0]          phase_mask;
    int                      scan_start;
    logic                    nxt_found;
    logic [PHW-1:0]          nxt_idx;
    logic                    arm_go;

    logic [ROWS-1:0]   rows_d;
    logic [COLS-1:0]   cols_d;
    logic [2*ROWS-1:0] rows_hb_d;
    logic [2*COLS-1:0] cols_hb_d;
    logic [PHW-1:0]    drv_col;
    logic [1:0]        drv_cmd;
    logic              ready_d, busy_d, trig_out_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) en_sync_q <= 2'b11;
        else       en_sync_q <= {en_sync_q[0], enable_n};
    end
    assign en_s = en_sync_q[1];

`ifdef ACTUATOR_SEQ_TRIGGER_EN
    logic [1:0] trig_sync_q;
    logic       trig_prev_q, trig_fall_q;

    // Edge is registered so SCAN starts one cycle after the synced fall is seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trig_sync_q <= 2'b11;
            trig_prev_q <= 1'b1;
            trig_fall_q <= 1'b0;
        end else begin
            trig_sync_q <= {trig_sync_q[0], trigger_in_n};
            trig_prev_q <= trig_sync_q[1];
            trig_fall_q <= trig_prev_q & ~trig_sync_q[1];
        end
    end
    assign arm_go = trig_fall_q;
`else
    logic unused_trig;
    assign unused_trig = trigger_in_n;
    assign arm_go      = 1'b1;
`endif

    // Bit 2c is column c forward, bit 2c+1 is column c reverse.
    always_comb begin
        phase_mask = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (frame_q[2*(c*ROWS+r) +: 2] == 2'b01) phase_mask[2*c]   = 1'b1;
                if (frame_q[2*(c*ROWS+r) +: 2] == 2'b10) phase_mask[2*c+1] = 1'b1;
            end
        end
    end

    always_comb begin
        scan_start = (state_q == StArm) ? 0 : int'(phase_q) + 1;
        nxt_found  = 1'b0;
        nxt_idx    = '0;
        for (int p = int'(NPH) - 1; p >= 0; p--) begin
            if (phase_mask[p] && p >= scan_start) begin
                nxt_found = 1'b1;
                nxt_idx   = PHW'(p);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        scan_next = 1'b0;
        case (state_q)
            StIdle: begin
                if (frame_valid && frame_ready && !en_s) begin
                    capture = 1'b1;
                    state_d = StArm;
                end
            end
            StArm:  scan_next = arm_go;
            StDead: begin
                if (cnt_q == '0) begin
                    state_d = StDrive;
                    cnt_d   = CW'(pulse_q) - CntOne;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StDrive: begin
                if (cnt_q == '0) scan_next = 1'b1;
                else             cnt_d     = cnt_q - CntOne;
            end
            StFinal: begin
                if (cnt_q == '0) state_d = StDone;
                else             cnt_d   = cnt_q - CntOne;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (scan_next) begin
            cnt_d = DeadLoad;
            if (nxt_found) begin
                state_d = StDead;
                phase_d = nxt_idx;
            end else begin
                state_d = StFinal;
            end
        end
        if (state_q != StIdle && en_s) state_d = StIdle;
    end

    // Outputs are computed from the next state so they register on state entry.
    always_comb begin
        rows_d    = '0;
        cols_d    = '0;
        rows_hb_d = '0;
        cols_hb_d = '0;
        drv_col   = phase_d >> 1;
        drv_cmd   = phase_d[0] ? 2'b10 : 2'b01;
        if (state_d == StDrive) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (PHW'(c) == drv_col) begin
                    cols_d[c]          = 1'b1;
                    cols_hb_d[2*c +: 2] = phase_d[0] ? 2'b10 : 2'b01;
                    for (int unsigned r = 0; r < ROWS; r++) begin
                        if (frame_q[2*(c*ROWS+r) +: 2] == drv_cmd) begin
                            rows_d[r]           = 1'b1;
                            rows_hb_d[2*r +: 2] = phase_d[0] ? 2'b01 : 2'b10;
                        end
                    end
                end
            end
        end
        busy_d  = (state_d != StIdle);
        ready_d = (state_d == StIdle) && !en_s;
`ifdef ACTUATOR_SEQ_TRIGGER_EN
        trig_out_d = (state_d != StDone);
`else
        trig_out_d = 1'b1;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            phase_q       <= '0;
            cnt_q         <= '0;
            frame_q       <= '0;
            pulse_q       <= '0;
            rows          <= '0;
            cols          <= '0;
            rows_hbrige   <= '0;
            cols_hbrige   <= '0;
            rows_enable   <= '0;
            cols_enable   <= '0;
            busy          <= 1'b0;
            frame_ready   <= 1'b0;
            trigger_out_n <= 1'b1;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            if (capture) begin
                frame_q <= frame_data;
                pulse_q <= (pulse_len == '0) ? PW'(1) : pulse_len;
            end
            rows          <= rows_d;
            cols          <= cols_d;
            rows_hbrige   <= rows_hb_d;
            cols_hbrige   <= cols_hb_d;
            rows_enable   <= {ROWS{busy_d}};
            cols_enable   <= {COLS{busy_d}};
            busy          <= busy_d;
            frame_ready   <= ready_d;
            trigger_out_n <= trig_out_d;
        end
    end

endmodule

// File: tb/tb_actuator_matrix_sequencer.sv
// Directed bench for actuator_matrix_sequencer (ROWS=5, COLS=2, DEAD_CYCLES=4).
// Trigger-gated scenario runs when ACTUATOR_SEQ_TRIGGER_EN is defined.
module tb_actuator_matrix_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_n;
    logic        trigger_in_n;
    logic [19:0] frame_data;
    logic [15:0] pulse_len;
    logic        frame_valid;
    logic        frame_ready;
    logic [4:0]  rows;
    logic [1:0]  cols;
    logic [4:0]  rows_enable;
    logic [1:0]  cols_enable;
    logic [9:0]  rows_hbrige;
    logic [3:0]  cols_hbrige;
    logic        trigger_out_n;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // {rows, cols, rows_hbrige, cols_hbrige}
    localparam logic [20:0] D21 = {5'b00100, 2'b10, 10'b0000100000, 4'b0100};
    localparam logic [20:0] DF  = {5'b00001, 2'b01, 10'b0000000010, 4'b0001};
    localparam logic [20:0] DR  = {5'b00010, 2'b01, 10'b0000000100, 4'b0010};

    actuator_matrix_sequencer #(
        .ROWS(5), .COLS(2), .DEAD_CYCLES(4), .PW(16)
    ) dut (
        .clock(clock), .reset(reset), .enable_n(enable_n), .trigger_in_n(trigger_in_n),
        .frame_data(frame_data), .pulse_len(pulse_len), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .rows(rows), .cols(cols), .rows_enable(rows_enable),
        .cols_enable(cols_enable), .rows_hbrige(rows_hbrige), .cols_hbrige(cols_hbrige),
        .trigger_out_n(trigger_out_n), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic has11();
        logic f = 1'b0;
        for (int i = 0; i < 5; i++) if (rows_hbrige[2*i +: 2] == 2'b11) f = 1'b1;
        for (int i = 0; i < 2; i++) if (cols_hbrige[2*i +: 2] == 2'b11) f = 1'b1;
        return f;
    endfunction

    task automatic cyc(input string tag, input logic [20:0] drv, input logic b, input logic rdy,
                       input logic trg);
        chk({tag, " drive"}, 32'({rows, cols, rows_hbrige, cols_hbrige}), 32'(drv));
        chk({tag, " busy/en"}, 32'({busy, rows_enable, cols_enable}), b ? 32'h0ff : 32'h0);
        chk({tag, " ready"}, 32'(frame_ready), 32'(rdy));
        chk({tag, " trig_out"}, 32'(trigger_out_n), 32'(trg));
        chk({tag, " pair11"}, 32'(has11()), 32'h0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Accept edge T happens inside; returns observing cycle T+1 with junk on the inputs.
    task automatic send(input logic [19:0] fd, input logic [15:0] pl);
        frame_data  = fd;
        pulse_len   = pl;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        frame_data  = ~fd;
        pulse_len   = 16'hffff;
    endtask

    task automatic reset_seq(input string tag);
        for (int i = 0; i < 2; i++) step();
        cyc({tag, " in reset"}, '0, 1'b0, 1'b0, 1'b1);
        step();
        reset = 1'b0;
        step();
        cyc({tag, " rel+1"}, '0, 1'b0, 1'b0, 1'b1);
        step();
        cyc({tag, " rel+2"}, '0, 1'b0, 1'b0, 1'b1);
        step();
        cyc({tag, " rel+3"}, '0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        reset        = 1'b1;
        enable_n     = 1'b0;
        trigger_in_n = 1'b1;
        frame_valid  = 1'b0;
        frame_data   = '0;
        pulse_len    = '0;
        reset_seq("reset");

`ifndef ACTUATOR_SEQ_TRIGGER_EN
        // Cell (2,1) forward only, pulse 3: column 0 skipped.
        send(20'h04000, 16'd3);
        for (int k = 1; k <= 14; k++) begin
            cyc("cell21", (k >= 6 && k <= 8) ? D21 : 21'h0, k <= 13, k == 14, 1'b1);
            if (k < 14) step();
        end

        // Column 0 forward row0 then reverse row1, pulse 2.
        send(20'h00009, 16'd2);
        for (int k = 1; k <= 19; k++) begin
            cyc("fwdrev", (k == 6 || k == 7) ? DF : (k == 12 || k == 13) ? DR : 21'h0,
                k <= 18, k == 19, 1'b1);
            if (k < 19) step();
        end

        // Empty frame: straight to FINAL.
        send(20'h00000, 16'd0);
        for (int k = 1; k <= 7; k++) begin
            cyc("empty", '0, k <= 6, k == 7, 1'b1);
            if (k < 7) step();
        end

        // pulse_len 0 with an active cell drives for one cycle.
        send(20'h00001, 16'd0);
        for (int k = 1; k <= 12; k++) begin
            cyc("pulse0", (k == 6) ? DF : 21'h0, k <= 11, k == 12, 1'b1);
            if (k < 12) step();
        end

        // Abort during second DRIVE cycle.
        send(20'h04000, 16'd10);
        for (int k = 1; k <= 7; k++) begin
            cyc("abort pre", (k >= 6) ? D21 : 21'h0, 1'b1, 1'b0, 1'b1);
            if (k < 7) step();
        end
        enable_n = 1'b1;
        step();
        cyc("abort E+1", D21, 1'b1, 1'b0, 1'b1);
        step();
        cyc("abort E+2", D21, 1'b1, 1'b0, 1'b1);
        step();
        cyc("abort E+3", '0, 1'b0, 1'b0, 1'b1);
        frame_valid = 1'b1;
        frame_data  = 20'h04000;
        pulse_len   = 16'd3;
        for (int k = 0; k < 15; k++) begin
            step();
            cyc("abort idle", '0, 1'b0, 1'b0, 1'b1);
        end
        frame_valid = 1'b0;
        enable_n    = 1'b0;
        step();
        step();
        cyc("reenable+2", '0, 1'b0, 1'b0, 1'b1);
        step();
        cyc("reenable+3", '0, 1'b0, 1'b1, 1'b1);
`else
        // Trigger-gated: hold in ARM 20 cycles, then falling trigger at pad edge F.
        send(20'h04000, 16'd3);
        for (int k = 1; k <= 20; k++) begin
            cyc("arm hold", '0, 1'b1, 1'b0, 1'b1);
            if (k < 20) step();
        end
        trigger_in_n = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            step();
            cyc("trig run", (j >= 8 && j <= 10) ? D21 : 21'h0, j <= 15, j == 16, j != 15);
        end
        trigger_in_n = 1'b1;
`endif

        // Asynchronous reset in the middle of a DRIVE window.
        send(20'h04000, 16'd10);
        for (int k = 2; k <= 7; k++) step();
`ifdef ACTUATOR_SEQ_TRIGGER_EN
        chk("async pre drive", 32'(rows), 32'h0);
`else
        chk("async pre drive", 32'(rows), 32'h04);
`endif
        #2;
        reset = 1'b1;
        #1;
        cyc("async reset", '0, 1'b0, 1'b0, 1'b1);
        reset_seq("reset2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
